cnn_mem_master: RTL and testbench

- Initiator side of the CNN feature/weight RAM port: the single `address` / `data_in` / `write_enable` bus, plus the 25-word combinational window output.
- Converts an incoming valid/ready stream of 16-bit words into a sequential burst of single-word RAM writes.
- Serves 25-word window-read requests from the conv datapath, returning a registered window.
- Sits between the layer sequencer / conv engine and the CNN RAM, and owns all traffic on that RAM port.

---
 rtl/cnn_mem_master.sv | 166 ++++++++++++++++
 tb/tb_cnn_mem_master.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_mem_master.sv
// Sole initiator on the CNN feature/weight RAM port: turns a valid/ready word stream
// into single-word RAM writes and serves registered 25-word window reads.
module cnn_mem_master #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int WIN       = 25,
  parameter int MEM_DEPTH = 2500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_start,
  input  logic [ADDR_W-1:0]     wr_base,
  input  logic [ADDR_W-1:0]     wr_len,
  input  logic                  wr_valid,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ready,
  output logic                  wr_done,
  output logic                  wr_err,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [WIN*DATA_W-1:0] rd_window,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_data_in,
  output logic                  mem_write_enable,
  input  logic [WIN*DATA_W-1:0] mem_data_out,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, WRITE, WDRAIN, READ} state_t;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] L_WIN   = (ADDR_W+1)'(WIN);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_W-1:0]     r_base;
  logic [ADDR_W-1:0]     r_len;
  logic [ADDR_W-1:0]     r_count;
  logic [ADDR_W-1:0]     r_mem_address;
  logic [DATA_W-1:0]     r_mem_data_in;
  logic                  r_mem_we;
  logic [WIN*DATA_W-1:0] r_rd_window;
  logic                  r_wr_done;
  logic                  r_wr_err;
  logic                  r_rd_ack;
  logic                  r_rd_err;

  logic w_wr_oob;
  logic w_rd_oob;
  logic w_len_zero;
  logic w_hs;
  logic w_last;

  // Bounds are computed one bit wider so that a base near the top of the address space cannot wrap.
  assign w_wr_oob   = ({1'b0, wr_base} + {1'b0, wr_len}) > L_DEPTH;
  assign w_rd_oob   = ({1'b0, rd_addr} + L_WIN) > L_DEPTH;
  assign w_len_zero = (wr_len == '0);
  assign w_hs       = wr_valid && (r_state == WRITE);
  assign w_last     = ((r_count + ADDR_W'(1)) == r_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (wr_start) begin
          if (!w_wr_oob && !w_len_zero) begin
            w_state_next = WRITE;
          end
        end else if (rd_req && !w_rd_oob) begin
          w_state_next = READ;
        end
      end
      WRITE: begin
        if (w_hs && w_last) begin
          w_state_next = WDRAIN;
        end
      end
      WDRAIN:  w_state_next = IDLE;
      READ:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base        <= '0;
      r_len         <= '0;
      r_count       <= '0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_mem_we      <= 1'b0;
      r_rd_window   <= '0;
      r_wr_done     <= 1'b0;
      r_wr_err      <= 1'b0;
      r_rd_ack      <= 1'b0;
      r_rd_err      <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_rd_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_mem_we <= 1'b0;
          // A simultaneous read request loses to the write and is simply dropped.
          if (wr_start) begin
            if (w_wr_oob) begin
              r_wr_err <= 1'b1;
            end else if (w_len_zero) begin
              r_wr_done <= 1'b1;
            end else begin
              r_base  <= wr_base;
              r_len   <= wr_len;
              r_count <= '0;
            end
          end else if (rd_req) begin
            if (w_rd_oob) begin
              r_rd_err <= 1'b1;
            end else begin
              r_mem_address <= rd_addr;
            end
          end
        end
        WRITE: begin
          if (w_hs) begin
            r_mem_address <= r_base + r_count;
            r_mem_data_in <= wr_data;
            r_mem_we      <= 1'b1;
            r_count       <= r_count + ADDR_W'(1);
          end else begin
            r_mem_we <= 1'b0;
          end
        end
        WDRAIN: begin
          r_mem_we  <= 1'b0;
          r_wr_done <= 1'b1;
        end
        READ: begin
          r_rd_window <= mem_data_out;
          r_rd_ack    <= 1'b1;
        end
        default: r_mem_we <= 1'b0;
      endcase
    end
  end

  assign wr_ready         = (r_state == WRITE);
  assign busy             = (r_state != IDLE);
  assign wr_done          = r_wr_done;
  assign wr_err           = r_wr_err;
  assign rd_window        = r_rd_window;
  assign rd_ack           = r_rd_ack;
  assign rd_err           = r_rd_err;
  assign mem_address      = r_mem_address;
  assign mem_data_in      = r_mem_data_in;
  assign mem_write_enable = r_mem_we;
endmodule

// File: tb/tb_cnn_mem_master.sv
// Self-checking bench for cnn_mem_master: a behavioural RAM on the port plus an
// expected-contents model updated from the burst/read rules.
module tb_cnn_mem_master;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int WIN       = 25;
  localparam int MEM_DEPTH = 2500;

  logic                  clk;
  logic                  rst;
  logic                  wr_start;
  logic [ADDR_W-1:0]     wr_base;
  logic [ADDR_W-1:0]     wr_len;
  logic                  wr_valid;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  wr_err;
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic [WIN*DATA_W-1:0] rd_window;
  logic                  rd_ack;
  logic                  rd_err;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W-1:0]     mem_data_in;
  logic                  mem_write_enable;
  logic [WIN*DATA_W-1:0] mem_data_out;
  logic                  busy;

  cnn_mem_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN(WIN), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .wr_base(wr_base), .wr_len(wr_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_done(wr_done), .wr_err(wr_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_window(rd_window),
    .rd_ack(rd_ack), .rd_err(rd_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CNN RAM: synchronous write, combinational window read.
  logic [DATA_W-1:0] ram [0:MEM_DEPTH-1];
  logic              tb_clear;
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < MEM_DEPTH; i++) ram[i] <= '0;
    end else if (mem_write_enable && (int'(mem_address) < MEM_DEPTH)) begin
      ram[mem_address] <= mem_data_in;
    end
  end
  always_comb begin
    mem_data_out = '0;
    for (int i = 0; i < WIN; i++) begin
      if (int'(mem_address) + i < MEM_DEPTH) mem_data_out[i*DATA_W +: DATA_W] = ram[int'(mem_address) + i];
    end
  end

  // Monitor: pulse counters and a log of every RAM write, sampled mid-cycle.
  int                n_wr_done = 0, n_wr_err = 0, n_rd_ack = 0, n_rd_err = 0, cyc = 0;
  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];
  int                log_cyc[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_done === 1'b1) n_wr_done <= n_wr_done + 1;
    if (wr_err === 1'b1) n_wr_err <= n_wr_err + 1;
    if (rd_ack === 1'b1) n_rd_ack <= n_rd_ack + 1;
    if (rd_err === 1'b1) n_rd_err <= n_rd_err + 1;
    if (mem_write_enable === 1'b1) begin
      log_addr.push_back(mem_address);
      log_data.push_back(mem_data_in);
      log_cyc.push_back(cyc);
    end
  end

  // Reference model state.
  int exp_ram [0:MEM_DEPTH-1];
  int exp_win [0:WIN-1];
  int burst_data [0:63];
  int n_checks = 0;
  int n_errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int base, input int len);
    for (int k = 0; k < len; k++) exp_ram[base+k] = burst_data[k] & 16'hFFFF;
  endtask

  task automatic model_read(input int addr);
    for (int i = 0; i < WIN; i++) exp_win[i] = exp_ram[addr+i];
  endtask

  // Stimulus only: runs one burst and reports how many cycles after the last handshake wr_done appeared.
  task automatic drive_burst(input int base, input int len, input bit stall, input bit collide,
                             input bit rd_in_write, output int lat, output bit to);
    int k, cycles;
    bit v, hs;
    wr_base  = 16'(base);
    wr_len   = 16'(len);
    wr_start = 1'b1;
    rd_req   = collide;
    rd_addr  = 16'd0;
    step();
    wr_start = 1'b0;
    rd_req   = rd_in_write;
    k = 0; cycles = 0; to = 1'b0;
    while (k < len && !to) begin
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_valid = v;
      wr_data  = 16'(burst_data[k]);
      hs = v && (wr_ready === 1'b1);
      step();
      if (hs) k++;
      cycles++;
      if (cycles > 2000) to = 1'b1;
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    lat = -1;
    for (int i = 1; i <= 4; i++) begin
      if (lat < 0) begin
        step();
        if (wr_done === 1'b1) lat = i;
      end
    end
  endtask

  // Stimulus only: one read request; lat is cycles from the sampling edge to rd_ack.
  task automatic drive_read(input int addr, output int lat, output bit busy1, output bit err1, output bit busy2);
    rd_req  = 1'b1;
    rd_addr = 16'(addr);
    step();
    rd_req = 1'b0;
    busy1  = busy;
    err1   = rd_err;
    busy2  = 1'b1;
    lat    = -1;
    for (int i = 1; i <= 3; i++) begin
      if (lat < 0) begin
        step();
        if (rd_ack === 1'b1) begin
          lat   = i;
          busy2 = busy;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tb_clear = 1'b1;
    wr_start = 1'b0; wr_base = '0; wr_len = '0; wr_valid = 1'b0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    repeat (3) step();
    n_checks++;
    if ({wr_ready, wr_done, wr_err, rd_ack, rd_err, mem_write_enable, busy} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000000", {wr_ready, wr_done, wr_err, rd_ack, rd_err, mem_write_enable, busy});
    end
    n_checks++;
    if (mem_address !== '0 || mem_data_in !== '0) begin
      n_errors++;
      $display("FAIL reset_mem_bus: got addr=%0h data=%0h expected 0/0", mem_address, mem_data_in);
    end
    n_checks++;
    if (rd_window !== '0) begin
      n_errors++;
      $display("FAIL reset_window: got %0h expected 0", rd_window);
    end
    rst = 1'b0; tb_clear = 1'b0;
    step();
    $display("reset: outputs checked");
  endtask

  task automatic test_write_burst();
    int lat, n0, d0;
    bit to;
    for (int k = 0; k < 4; k++) burst_data[k] = 32'hA0 + k;
    n0 = log_addr.size(); d0 = n_wr_done;
    drive_burst(100, 4, 1'b0, 1'b0, 1'b0, lat, to);
    step();
    model_write(100, 4);
    n_checks++;
    if (to || lat != 1) begin
      n_errors++;
      $display("FAIL wr_done_latency: got %0d (timeout=%0d) expected 1", lat, to);
    end
    n_checks++;
    if (n_wr_done - d0 != 1) begin
      n_errors++;
      $display("FAIL wr_done_count: got %0d expected 1", n_wr_done - d0);
    end
    n_checks++;
    if (log_addr.size() - n0 != 4) begin
      n_errors++;
      $display("FAIL burst_write_count: got %0d expected 4", log_addr.size() - n0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (log_addr[n0+k] !== 16'(100 + k) || log_data[n0+k] !== 16'(exp_ram[100+k]) || log_cyc[n0+k] != log_cyc[n0] + k) begin
          n_errors++;
          $display("FAIL burst_write_%0d: got addr=%0d data=%0h cyc+%0d expected addr=%0d data=%0h cyc+%0d",
                   k, log_addr[n0+k], log_data[n0+k], log_cyc[n0+k] - log_cyc[n0], 100 + k, exp_ram[100+k], k);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ram[100+k] !== 16'(exp_ram[100+k])) begin
        n_errors++;
        $display("FAIL burst_ram_%0d: got %0h expected %0h", 100 + k, ram[100+k], exp_ram[100+k]);
      end
    end
    $display("write burst base=100 len=4 done_lat=%0d", lat);
  endtask

  task automatic test_read_after_write();
    int lat, rlat, l0, a0;
    bit to, b1, e1, b2, bad;
    for (int k = 0; k < 25; k++) burst_data[k] = k;
    drive_burst(200, 25, 1'b0, 1'b0, 1'b0, lat, to);
    model_write(200, 25);
    l0 = log_addr.size(); a0 = n_rd_ack;
    drive_read(200, rlat, b1, e1, b2);
    step();
    model_read(200);
    n_checks++;
    if (to || lat != 1) begin
      n_errors++;
      $display("FAIL raw_burst_done: got %0d (timeout=%0d) expected 1", lat, to);
    end
    n_checks++;
    if (rlat != 1 || n_rd_ack - a0 != 1) begin
      n_errors++;
      $display("FAIL raw_ack: got latency %0d count %0d expected 1/1", rlat, n_rd_ack - a0);
    end
    n_checks++;
    if (b1 !== 1'b1 || b2 !== 1'b0) begin
      n_errors++;
      $display("FAIL raw_busy: got %b%b expected 10", b1, b2);
    end
    bad = 1'b0;
    for (int i = 0; i < WIN; i++) if (rd_window[i*DATA_W +: DATA_W] !== 16'(exp_win[i])) bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL raw_window: got %0h expected words 0..24", rd_window);
    end
    n_checks++;
    if (log_addr.size() != l0) begin
      n_errors++;
      $display("FAIL raw_no_write: got %0d writes expected 0", log_addr.size() - l0);
    end
    $display("read after write addr=200 ack_lat=%0d", rlat);
  endtask

  task automatic test_bounds();
    int rlat, l0, e0, d0;
    bit b1, e1, b2, bad;
    e0 = n_rd_err;
    drive_read(2476, rlat, b1, e1, b2);
    step();
    n_checks++;
    if (e1 !== 1'b1 || rlat != -1 || b1 !== 1'b0 || n_rd_err - e0 != 1) begin
      n_errors++;
      $display("FAIL rd_oob_2476: got err=%b ack_lat=%0d busy=%b errs=%0d expected 1/-1/0/1", e1, rlat, b1, n_rd_err - e0);
    end
    bad = 1'b0;
    for (int i = 0; i < WIN; i++) if (rd_window[i*DATA_W +: DATA_W] !== 16'(exp_win[i])) bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL rd_oob_window_held: got %0h expected previous window", rd_window);
    end
    drive_read(2475, rlat, b1, e1, b2);
    model_read(2475);
    bad = 1'b0;
    for (int i = 0; i < WIN; i++) if (rd_window[i*DATA_W +: DATA_W] !== 16'(exp_win[i])) bad = 1'b1;
    n_checks++;
    if (rlat != 1 || e1 !== 1'b0 || bad) begin
      n_errors++;
      $display("FAIL rd_edge_2475: got ack_lat=%0d err=%b window_bad=%b expected 1/0/0", rlat, e1, bad);
    end
    l0 = log_addr.size();
    wr_base = 16'd2498; wr_len = 16'd3; wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    n_checks++;
    if (wr_err !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_oob_2498: got err=%b busy=%b expected 1/0", wr_err, busy);
    end
    wr_base = 16'hFFFF; wr_len = 16'd2; wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    n_checks++;
    if (wr_err !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_oob_wrap: got err=%b busy=%b expected 1/0", wr_err, busy);
    end
    d0 = n_wr_done;
    wr_base = 16'd50; wr_len = 16'd0; wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    n_checks++;
    if (wr_done !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_len0: got done=%b busy=%b expected 1/0", wr_done, busy);
    end
    repeat (3) step();
    n_checks++;
    if (log_addr.size() != l0 || n_wr_done - d0 != 1) begin
      n_errors++;
      $display("FAIL bounds_no_write: got writes=%0d dones=%0d expected 0/1", log_addr.size() - l0, n_wr_done - d0);
    end
    $display("bounds: rd 2476/2475, wr 2498+3, wrap, len0");
  endtask

  task automatic test_stalls();
    bit pat [0:5];
    int k, n0, lat;
    bit hs;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int j = 0; j < 3; j++) burst_data[j] = $urandom_range(0, 16'hFFFF);
    n0 = log_addr.size();
    wr_base = 16'd300; wr_len = 16'd3; wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    k = 0;
    for (int j = 0; j < 6; j++) begin
      wr_valid = pat[j];
      wr_data  = 16'(burst_data[k]);
      hs = pat[j] && (wr_ready === 1'b1);
      step();
      if (hs) k++;
    end
    wr_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 4; i++) begin
      if (lat < 0) begin
        step();
        if (wr_done === 1'b1) lat = i;
      end
    end
    step();
    model_write(300, 3);
    n_checks++;
    if (lat != 1) begin
      n_errors++;
      $display("FAIL stall_done: got latency %0d expected 1", lat);
    end
    n_checks++;
    if (log_addr.size() - n0 != 3) begin
      n_errors++;
      $display("FAIL stall_write_count: got %0d expected 3", log_addr.size() - n0);
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (log_addr[n0+j] !== 16'(300 + j) || log_data[n0+j] !== 16'(exp_ram[300+j])) begin
          n_errors++;
          $display("FAIL stall_write_%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                   j, log_addr[n0+j], log_data[n0+j], 300 + j, exp_ram[300+j]);
        end
      end
      n_checks++;
      if (log_cyc[n0+1] - log_cyc[n0] != 3 || log_cyc[n0+2] - log_cyc[n0] != 5) begin
        n_errors++;
        $display("FAIL stall_timing: got offsets %0d,%0d expected 3,5",
                 log_cyc[n0+1] - log_cyc[n0], log_cyc[n0+2] - log_cyc[n0]);
      end
    end
    $display("stall burst base=300 len=3 pattern 100101");
  endtask

  task automatic test_collision();
    int lat, n0, a0, e0;
    bit to, bad;
    for (int k = 0; k < 5; k++) burst_data[k] = $urandom_range(0, 16'hFFFF);
    n0 = log_addr.size(); a0 = n_rd_ack; e0 = n_rd_err;
    drive_burst(400, 5, 1'b0, 1'b1, 1'b1, lat, to);
    repeat (2) step();
    model_write(400, 5);
    n_checks++;
    if (to || lat != 1) begin
      n_errors++;
      $display("FAIL collide_done: got %0d (timeout=%0d) expected 1", lat, to);
    end
    n_checks++;
    if (n_rd_ack != a0 || n_rd_err != e0) begin
      n_errors++;
      $display("FAIL collide_read_dropped: got acks=%0d errs=%0d expected 0/0", n_rd_ack - a0, n_rd_err - e0);
    end
    bad = (log_addr.size() - n0 != 5);
    if (!bad) for (int k = 0; k < 5; k++)
      if (log_addr[n0+k] !== 16'(400 + k) || log_data[n0+k] !== 16'(exp_ram[400+k])) bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL collide_writes: got %0d writes expected 5 to 400..404", log_addr.size() - n0);
    end
    $display("collision burst base=400 len=5 with rd_req at start and during write");
  endtask

  task automatic test_reset_mid();
    int n0, d0, lat;
    bit to, bad;
    for (int k = 0; k < 5; k++) burst_data[k] = $urandom_range(0, 16'hFFFF);
    n0 = log_addr.size(); d0 = n_wr_done;
    wr_base = 16'd600; wr_len = 16'd5; wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1;
      wr_data  = 16'(burst_data[k]);
      step();
    end
    rst = 1'b1; wr_valid = 1'b0;
    step();
    model_write(600, 2);
    for (int i = 0; i < WIN; i++) exp_win[i] = 0;
    n_checks++;
    if ({wr_ready, wr_done, wr_err, rd_ack, rd_err, mem_write_enable, busy} !== 7'b0 ||
        mem_address !== '0 || mem_data_in !== '0 || rd_window !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got flags=%b addr=%0h data=%0h expected all 0",
               {wr_ready, wr_done, wr_err, rd_ack, rd_err, mem_write_enable, busy}, mem_address, mem_data_in);
    end
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if (n_wr_done != d0 || log_addr.size() - n0 != 2) begin
      n_errors++;
      $display("FAIL midreset_abandon: got dones=%0d writes=%0d expected 0/2", n_wr_done - d0, log_addr.size() - n0);
    end
    n_checks++;
    if (ram[600] !== 16'(exp_ram[600]) || ram[601] !== 16'(exp_ram[601])) begin
      n_errors++;
      $display("FAIL midreset_ram_kept: got %0h %0h expected %0h %0h", ram[600], ram[601], exp_ram[600], exp_ram[601]);
    end
    for (int k = 0; k < 3; k++) burst_data[k] = $urandom_range(0, 16'hFFFF);
    n0 = log_addr.size();
    drive_burst(700, 3, 1'b0, 1'b0, 1'b0, lat, to);
    step();
    model_write(700, 3);
    bad = to || (lat != 1) || (log_addr.size() - n0 != 3);
    if (!bad) for (int k = 0; k < 3; k++)
      if (log_addr[n0+k] !== 16'(700 + k) || log_data[n0+k] !== 16'(exp_ram[700+k])) bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL midreset_restart: got %0d writes lat=%0d expected 3 writes to 700..702 lat=1", log_addr.size() - n0, lat);
    end
    $display("reset mid-burst base=600, restart base=700");
  endtask

  task automatic test_random();
    int base, len, lat, rlat, ra, n0;
    bit to, b1, e1, b2, bad;
    for (int it = 0; it < 10; it++) begin
      len  = $urandom_range(1, 40);
      base = $urandom_range(0, MEM_DEPTH - len);
      for (int k = 0; k < len; k++) burst_data[k] = $urandom_range(0, 16'hFFFF);
      n0 = log_addr.size();
      drive_burst(base, len, 1'b1, 1'b0, 1'b0, lat, to);
      model_write(base, len);
      bad = to || (lat != 1) || (log_addr.size() - n0 != len);
      if (!bad) for (int k = 0; k < len; k++)
        if (log_addr[n0+k] !== 16'(base + k) || log_data[n0+k] !== 16'(exp_ram[base+k])) bad = 1'b1;
      n_checks++;
      if (bad) begin
        n_errors++;
        $display("FAIL rand_burst_%0d: got %0d writes lat=%0d expected %0d writes lat=1", it, log_addr.size() - n0, lat, len);
      end
      ra = base - $urandom_range(0, 24);
      if (ra < 0) ra = 0;
      if (ra > MEM_DEPTH - WIN) ra = MEM_DEPTH - WIN;
      drive_read(ra, rlat, b1, e1, b2);
      model_read(ra);
      bad = (rlat != 1);
      for (int i = 0; i < WIN; i++) if (rd_window[i*DATA_W +: DATA_W] !== 16'(exp_win[i])) bad = 1'b1;
      n_checks++;
      if (bad) begin
        n_errors++;
        $display("FAIL rand_read_%0d: got ack_lat=%0d window=%0h at addr %0d", it, rlat, rd_window, ra);
      end
      $display("random %0d: burst base=%0d len=%0d, read addr=%0d", it, base, len, ra);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) exp_ram[i] = 0;
    for (int i = 0; i < WIN; i++) exp_win[i] = 0;
    test_reset();
    test_write_burst();
    test_read_after_write();
    test_bounds();
    test_stalls();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
